mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage: forwards ALU ops and runs a two-state load/store handshake.
// Optional define MEM_ALIGN_CHECK_EN faults misaligned halfword/word accesses instead of issuing them.
module mem_access_stage #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REG_FILE_ADDR = 5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_IE_valid,
  input  logic [DATA_WIDTH-1:0]    i_IE_result,
  input  logic [DATA_WIDTH-1:0]    i_IE_data_write,
  input  logic [REG_FILE_ADDR-1:0] i_IE_rd_addr,
  input  logic                     i_ctrl_mem_read,
  input  logic                     i_ctrl_mem_write,
  input  logic [2:0]               i_ctrl_mem_funct3,
  input  logic                     i_ctrl_reg_write,
  output logic                     o_MEM_stall,
  output logic                     o_dmem_req,
  output logic                     o_dmem_we,
  output logic [DATA_WIDTH-1:0]    o_dmem_addr,
  output logic [DATA_WIDTH-1:0]    o_dmem_wdata,
  output logic [3:0]               o_dmem_be,
  input  logic                     i_dmem_ack,
  input  logic [DATA_WIDTH-1:0]    i_dmem_rdata,
  output logic                     o_MEM_valid,
  output logic [DATA_WIDTH-1:0]    o_MEM_result,
  output logic [DATA_WIDTH-1:0]    o_MEM_read_data,
  output logic [REG_FILE_ADDR-1:0] o_MEM_rd_addr,
  output logic                     o_MEM_reg_write,
  output logic                     o_MEM_access_fault
);

  typedef enum logic {StIdle = 1'b0, StWait = 1'b1} state_e;
  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0]    addr_q, wdata_q, result_q;
  logic [3:0]               be_q;
  logic                     we_q, reg_write_q;
  logic [2:0]               funct3_q;
  logic [1:0]               lane_q;
  logic [REG_FILE_ADDR-1:0] rd_q;

  logic                     valid_q, reg_write_out_q, fault_q;
  logic [DATA_WIDTH-1:0]    result_out_q, read_data_q;
  logic [REG_FILE_ADDR-1:0] rd_out_q;

  logic                     valid_d, reg_write_out_d, fault_d;
  logic [DATA_WIDTH-1:0]    result_out_d, read_data_d;
  logic [REG_FILE_ADDR-1:0] rd_out_d;

  logic                  is_mem, bad_funct3, bad_access, accept, ack;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata, byte_shift, half_shift, load_data;

  assign is_mem     = i_ctrl_mem_read | i_ctrl_mem_write;
  assign bad_funct3 = (i_ctrl_mem_funct3 == 3'b011) || (i_ctrl_mem_funct3[2:1] == 2'b11);
`ifdef MEM_ALIGN_CHECK_EN
  assign bad_access = is_mem & (bad_funct3 |
                      ((i_ctrl_mem_funct3[1:0] == 2'b01) & i_IE_result[0]) |
                      ((i_ctrl_mem_funct3[1:0] == 2'b10) & (i_IE_result[1:0] != 2'b00)));
`else
  assign bad_access = is_mem & bad_funct3;
`endif
  assign accept = (state_q == StIdle) & i_IE_valid & is_mem & ~bad_access;
  // Ack only counts while a request is outstanding.
  assign ack    = (state_q == StWait) & i_dmem_ack;

  assign o_MEM_stall  = accept | ((state_q == StWait) & ~i_dmem_ack);
  assign o_dmem_req   = (state_q == StWait);
  assign o_dmem_we    = o_dmem_req & we_q;
  assign o_dmem_addr  = o_dmem_req ? addr_q  : '0;
  assign o_dmem_wdata = o_dmem_req ? wdata_q : '0;
  assign o_dmem_be    = o_dmem_req ? be_q    : 4'b0000;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = '0;
    if (i_ctrl_mem_write) begin
      case (i_ctrl_mem_funct3[1:0])
        2'b00: begin
          st_be    = 4'b0001 << i_IE_result[1:0];
          st_wdata = {4{i_IE_data_write[7:0]}};
        end
        2'b01: begin
          st_be    = 4'b0011 << {i_IE_result[1], 1'b0};
          st_wdata = {2{i_IE_data_write[15:0]}};
        end
        default: st_wdata = i_IE_data_write;
      endcase
    end
  end

  always_comb begin
    byte_shift = i_dmem_rdata >> {lane_q, 3'b000};
    half_shift = i_dmem_rdata >> {lane_q[1], 4'b0000};
    case (funct3_q)
      3'b000:  load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
      3'b001:  load_data = {{16{half_shift[15]}}, half_shift[15:0]};
      3'b100:  load_data = {24'h0, byte_shift[7:0]};
      3'b101:  load_data = {16'h0, half_shift[15:0]};
      default: load_data = i_dmem_rdata;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    valid_d         = 1'b0;
    result_out_d    = result_out_q;
    read_data_d     = read_data_q;
    rd_out_d        = rd_out_q;
    reg_write_out_d = reg_write_out_q;
    fault_d         = fault_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
        end else if (i_IE_valid) begin
          // ALU ops and faulting memory ops retire directly.
          valid_d         = 1'b1;
          result_out_d    = i_IE_result;
          read_data_d     = '0;
          rd_out_d        = i_IE_rd_addr;
          reg_write_out_d = i_ctrl_reg_write & ~bad_access;
          fault_d         = bad_access;
        end
      end
      StWait: begin
        if (ack) begin
          state_d         = StIdle;
          valid_d         = 1'b1;
          result_out_d    = result_q;
          read_data_d     = we_q ? '0 : load_data;
          rd_out_d        = rd_q;
          reg_write_out_d = reg_write_q;
          fault_d         = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      wdata_q         <= '0;
      result_q        <= '0;
      be_q            <= 4'b0000;
      we_q            <= 1'b0;
      reg_write_q     <= 1'b0;
      funct3_q        <= 3'b000;
      lane_q          <= 2'b00;
      rd_q            <= '0;
      valid_q         <= 1'b0;
      result_out_q    <= '0;
      read_data_q     <= '0;
      rd_out_q        <= '0;
      reg_write_out_q <= 1'b0;
      fault_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      result_out_q    <= result_out_d;
      read_data_q     <= read_data_d;
      rd_out_q        <= rd_out_d;
      reg_write_out_q <= reg_write_out_d;
      fault_q         <= fault_d;
      if (accept) begin
        addr_q      <= {i_IE_result[DATA_WIDTH-1:2], 2'b00};
        wdata_q     <= st_wdata;
        result_q    <= i_IE_result;
        be_q        <= st_be;
        we_q        <= i_ctrl_mem_write;
        reg_write_q <= i_ctrl_reg_write;
        funct3_q    <= i_ctrl_mem_funct3;
        lane_q      <= i_IE_result[1:0];
        rd_q        <= i_IE_rd_addr;
      end
    end
  end

  assign o_MEM_valid        = valid_q;
  assign o_MEM_result       = result_out_q;
  assign o_MEM_read_data    = read_data_q;
  assign o_MEM_rd_addr      = rd_out_q;
  assign o_MEM_reg_write    = reg_write_out_q;
  assign o_MEM_access_fault = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected retirements are queued at issue and
// compared when o_MEM_valid fires. Honours MEM_ALIGN_CHECK_EN for the misaligned-LW case.
module tb_mem_access_stage;

  logic        clk;
  logic        i_reset;
  logic        i_IE_valid;
  logic [31:0] i_IE_result, i_IE_data_write;
  logic [4:0]  i_IE_rd_addr;
  logic        i_ctrl_mem_read, i_ctrl_mem_write, i_ctrl_reg_write;
  logic [2:0]  i_ctrl_mem_funct3;
  logic        o_MEM_stall, o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_MEM_valid, o_MEM_reg_write, o_MEM_access_fault;
  logic [31:0] o_MEM_result, o_MEM_read_data;
  logic [4:0]  o_MEM_rd_addr;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        regw;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_access_stage #(.DATA_WIDTH(32), .REG_FILE_ADDR(5)) dut (
    .i_clk              (clk),
    .i_reset            (i_reset),
    .i_IE_valid         (i_IE_valid),
    .i_IE_result        (i_IE_result),
    .i_IE_data_write    (i_IE_data_write),
    .i_IE_rd_addr       (i_IE_rd_addr),
    .i_ctrl_mem_read    (i_ctrl_mem_read),
    .i_ctrl_mem_write   (i_ctrl_mem_write),
    .i_ctrl_mem_funct3  (i_ctrl_mem_funct3),
    .i_ctrl_reg_write   (i_ctrl_reg_write),
    .o_MEM_stall        (o_MEM_stall),
    .o_dmem_req         (o_dmem_req),
    .o_dmem_we          (o_dmem_we),
    .o_dmem_addr        (o_dmem_addr),
    .o_dmem_wdata       (o_dmem_wdata),
    .o_dmem_be          (o_dmem_be),
    .i_dmem_ack         (i_dmem_ack),
    .i_dmem_rdata       (i_dmem_rdata),
    .o_MEM_valid        (o_MEM_valid),
    .o_MEM_result       (o_MEM_result),
    .o_MEM_read_data    (o_MEM_read_data),
    .o_MEM_rd_addr      (o_MEM_rd_addr),
    .o_MEM_reg_write    (o_MEM_reg_write),
    .o_MEM_access_fault (o_MEM_access_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_MEM_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", o_MEM_valid, 1'b0);
      end else begin
        e_mon = exp_q.pop_front();
        check("sb_result", o_MEM_result, e_mon.result);
        check("sb_read_data", o_MEM_read_data, e_mon.rdata);
        check("sb_rd_addr", o_MEM_rd_addr, e_mon.rd);
        check("sb_reg_write", o_MEM_reg_write, e_mon.regw);
        check("sb_fault", o_MEM_access_fault, e_mon.fault);
      end
    end
  end

  task automatic idle_inputs();
    i_IE_valid       = 1'b0;
    i_ctrl_mem_read  = 1'b0;
    i_ctrl_mem_write = 1'b0;
    i_dmem_ack       = 1'b0;
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3, input logic regw,
                          input logic [31:0] res, input logic [31:0] wdat, input logic [4:0] rda);
    i_IE_valid        = 1'b1;
    i_ctrl_mem_read   = rd;
    i_ctrl_mem_write  = wr;
    i_ctrl_mem_funct3 = f3;
    i_ctrl_reg_write  = regw;
    i_IE_result       = res;
    i_IE_data_write   = wdat;
    i_IE_rd_addr      = rda;
  endtask

  task automatic push_exp(input logic [31:0] res, input logic [31:0] rdata, input logic [4:0] rd,
                          input logic regw, input logic fault);
    exp_t e;
    e.result = res; e.rdata = rdata; e.rd = rd; e.regw = regw; e.fault = fault;
    exp_q.push_back(e);
  endtask

  // Single-cycle retirement (ALU op or faulting memory op): no stall, no request.
  task automatic single_retire(input string tag);
    @(negedge clk);
    check({tag, "_stall"}, o_MEM_stall, 1'b0);
    check({tag, "_noreq"}, o_dmem_req, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check({tag, "_valid"}, o_MEM_valid, 1'b1);
    check({tag, "_noreq2"}, o_dmem_req, 1'b0);
    @(posedge clk); #1;
  endtask

  // Called with a memory op already driven in the acceptance cycle; acks in WAIT cycle `waits`.
  task automatic mem_op(input string tag, input int waits, input logic [31:0] rdata,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic e_we);
    @(negedge clk);
    check({tag, "_acc_stall"}, o_MEM_stall, 1'b1);
    check({tag, "_acc_noreq"}, o_dmem_req, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < waits; k++) begin
      i_dmem_ack   = (k == waits - 1);
      i_dmem_rdata = (k == waits - 1) ? rdata : 32'h0;
      @(negedge clk);
      check({tag, "_req"}, o_dmem_req, 1'b1);
      check({tag, "_we"}, o_dmem_we, e_we);
      check({tag, "_addr"}, o_dmem_addr, e_addr);
      check({tag, "_be"}, o_dmem_be, e_be);
      if (e_we) check({tag, "_wdata"}, o_dmem_wdata, e_wdata);
      check({tag, "_stall"}, o_MEM_stall, (k != waits - 1));
      @(posedge clk); #1;
    end
    idle_inputs();
    i_dmem_rdata = 32'h0;
    @(negedge clk);
    check({tag, "_valid"}, o_MEM_valid, 1'b1);
    check({tag, "_req_drop"}, o_dmem_req, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_pulse"}, o_MEM_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    i_reset = 1'b1;
    idle_inputs();
    i_ctrl_mem_funct3 = 3'b000;
    i_ctrl_reg_write  = 1'b0;
    i_IE_result       = 32'h0;
    i_IE_data_write   = 32'h0;
    i_IE_rd_addr      = 5'd0;
    i_dmem_rdata      = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", o_MEM_stall, 1'b0);
    check("rst_req", o_dmem_req, 1'b0);
    check("rst_we", o_dmem_we, 1'b0);
    check("rst_addr", o_dmem_addr, 32'h0);
    check("rst_wdata", o_dmem_wdata, 32'h0);
    check("rst_be", o_dmem_be, 4'h0);
    check("rst_valid", o_MEM_valid, 1'b0);
    check("rst_result", o_MEM_result, 32'h0);
    check("rst_rdata", o_MEM_read_data, 32'h0);
    check("rst_rd", o_MEM_rd_addr, 5'd0);
    check("rst_regw", o_MEM_reg_write, 1'b0);
    check("rst_fault", o_MEM_access_fault, 1'b0);
    @(posedge clk); #1;
    i_reset = 1'b0;

    drive_op(1'b0, 1'b0, 3'b000, 1'b1, 32'h0000_1234, 32'h0, 5'd5);
    push_exp(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0);
    single_retire("alu");

    // Ack while idle must be ignored.
    i_dmem_ack = 1'b1;
    @(negedge clk);
    check("idle_ack_stall", o_MEM_stall, 1'b0);
    @(posedge clk); #1;
    i_dmem_ack = 1'b0;

    drive_op(1'b0, 1'b1, 3'b000, 1'b0, 32'h0000_0103, 32'h0000_00AB, 5'd1);
    push_exp(32'h0000_0103, 32'h0, 5'd1, 1'b0, 1'b0);
    mem_op("sb", 3, 32'h0, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 1'b1);

    drive_op(1'b1, 1'b0, 3'b000, 1'b1, 32'h0000_0102, 32'h0, 5'd7);
    push_exp(32'h0000_0102, 32'hFFFF_FF80, 5'd7, 1'b1, 1'b0);
    mem_op("lb", 1, 32'h0080_0000, 32'h0000_0100, 4'b1111, 32'h0, 1'b0);

    drive_op(1'b1, 1'b0, 3'b100, 1'b1, 32'h0000_0102, 32'h0, 5'd8);
    push_exp(32'h0000_0102, 32'h0000_0080, 5'd8, 1'b1, 1'b0);
    mem_op("lbu", 1, 32'h0080_0000, 32'h0000_0100, 4'b1111, 32'h0, 1'b0);

    drive_op(1'b0, 1'b1, 3'b001, 1'b0, 32'h0000_0102, 32'h0000_5678, 5'd2);
    push_exp(32'h0000_0102, 32'h0, 5'd2, 1'b0, 1'b0);
    mem_op("sh", 2, 32'h0, 32'h0000_0100, 4'b1100, 32'h5678_5678, 1'b1);

    drive_op(1'b1, 1'b0, 3'b001, 1'b1, 32'h0000_0102, 32'h0, 5'd9);
    push_exp(32'h0000_0102, 32'hFFFF_8001, 5'd9, 1'b1, 1'b0);
    mem_op("lh", 1, 32'h8001_0000, 32'h0000_0100, 4'b1111, 32'h0, 1'b0);

    drive_op(1'b1, 1'b0, 3'b101, 1'b1, 32'h0000_0102, 32'h0, 5'd10);
    push_exp(32'h0000_0102, 32'h0000_8001, 5'd10, 1'b1, 1'b0);
    mem_op("lhu", 2, 32'h8001_0000, 32'h0000_0100, 4'b1111, 32'h0, 1'b0);

    // Read and write both set: the write wins.
    drive_op(1'b1, 1'b1, 3'b010, 1'b0, 32'h0000_0104, 32'hCAFE_F00D, 5'd3);
    push_exp(32'h0000_0104, 32'h0, 5'd3, 1'b0, 1'b0);
    mem_op("sw_rw", 1, 32'h1111_1111, 32'h0000_0104, 4'b1111, 32'hCAFE_F00D, 1'b1);

`ifdef MEM_ALIGN_CHECK_EN
    drive_op(1'b1, 1'b0, 3'b010, 1'b1, 32'h0000_0202, 32'h0, 5'd11);
    push_exp(32'h0000_0202, 32'h0, 5'd11, 1'b0, 1'b1);
    single_retire("lw_mis");
`else
    drive_op(1'b1, 1'b0, 3'b010, 1'b1, 32'h0000_0202, 32'h0, 5'd11);
    push_exp(32'h0000_0202, 32'hDEAD_BEEF, 5'd11, 1'b1, 1'b0);
    mem_op("lw_mis", 1, 32'hDEAD_BEEF, 32'h0000_0200, 4'b1111, 32'h0, 1'b0);
`endif

    // Reset during the second WAIT cycle abandons the request.
    drive_op(1'b1, 1'b0, 3'b010, 1'b1, 32'h0000_0300, 32'h0, 5'd12);
    @(negedge clk);
    check("rw_acc_stall", o_MEM_stall, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rw_wait1_req", o_dmem_req, 1'b1);
    @(posedge clk); #1;
    i_reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("rw_wait2_req", o_dmem_req, 1'b1);
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(negedge clk);
    check("rw_req_drop", o_dmem_req, 1'b0);
    check("rw_no_valid", o_MEM_valid, 1'b0);
    check("rw_stall", o_MEM_stall, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    drive_op(1'b0, 1'b1, 3'b011, 1'b1, 32'h0000_0400, 32'h1234_5678, 5'd13);
    push_exp(32'h0000_0400, 32'h0, 5'd13, 1'b0, 1'b1);
    single_retire("st_f3_011");

    drive_op(1'b0, 1'b0, 3'b000, 1'b0, 32'h8765_4321, 32'h0, 5'd31);
    push_exp(32'h8765_4321, 32'h0, 5'd31, 1'b0, 1'b0);
    single_retire("alu2");

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
